// File: rtl/npc_mem_arbiter_if.sv
// Bundle of IFU, LSU and memory-bridge signals around the NPC memory arbiter.
// Latency: none; this file only groups wires.
// Backpressure: held req lines, with a gnt pulse on each side.
`timescale 1ns/1ps
interface npc_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ifu_req;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_gnt;
    logic              ifu_rvalid;
    logic [DATA_W-1:0] ifu_rdata;

    logic              lsu_req;
    logic              lsu_we;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic [3:0]        lsu_wmask;
    logic              lsu_gnt;
    logic              lsu_rvalid;
    logic [DATA_W-1:0] lsu_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    logic              arb_err;

    // Arbiter side.
    modport slave (
        input  ifu_req, ifu_addr,
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output ifu_gnt, ifu_rvalid, ifu_rdata,
        output lsu_gnt, lsu_rvalid, lsu_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output arb_err
    );

    // Core and bridge side.
    modport master (
        output ifu_req, ifu_addr,
        output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  ifu_gnt, ifu_rvalid, ifu_rdata,
        input  lsu_gnt, lsu_rvalid, lsu_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  arb_err
    );
endinterface

// File: rtl/npc_mem_arbiter.sv
// Round-robin IFU/LSU sharing of one pmem port. Optional abort watchdog: NPC_ARB_TIMEOUT_EN.
// Latency: gnt one cycle after capture; rvalid is combinational from mem_rvalid; one idle bubble after each transaction.
// Backpressure: requesters hold req until gnt; mem_req is held until mem_gnt.
`timescale 1ns/1ps
module npc_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef NPC_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic             clk,
    input  logic             reset,
    npc_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner_lsu;
    logic              any_req;
    logic              pick_lsu;
    logic              capture;
    logic              complete;
    logic              abort;
    logic              finish;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign any_req  = bus.ifu_req | bus.lsu_req;
    // On a tie the port that did not own the last transaction wins.
    assign pick_lsu = bus.lsu_req & (~bus.ifu_req | ~owner_lsu);
    assign capture  = (state == IDLE) & any_req;
    assign complete = ((state == ISSUE) & bus.mem_gnt & bus.mem_rvalid) |
                      ((state == WAIT) & bus.mem_rvalid);
    assign finish   = complete | abort;

    assign sel_addr  = pick_lsu ? bus.lsu_addr : bus.ifu_addr;
    assign sel_wdata = pick_lsu ? bus.lsu_wdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.mem_req = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.mem_req = ~abort;
                if (finish)           state_nxt = IDLE;
                else if (bus.mem_gnt) state_nxt = WAIT;
            end
            WAIT: begin
                if (finish) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_lsu     <= 1'b0;
            bus.ifu_gnt   <= 1'b0;
            bus.lsu_gnt   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wmask <= '0;
        end else begin
            bus.ifu_gnt <= 1'b0;
            bus.lsu_gnt <= 1'b0;
            if (capture) begin
                owner_lsu     <= pick_lsu;
                bus.ifu_gnt   <= ~pick_lsu;
                bus.lsu_gnt   <= pick_lsu;
                bus.mem_we    <= pick_lsu & bus.lsu_we;
                bus.mem_addr  <= sel_addr;
                bus.mem_wdata <= sel_wdata;
                bus.mem_wmask <= pick_lsu ? bus.lsu_wmask : 4'b0000;
            end
        end
    end

    assign bus.ifu_rvalid = finish & ~owner_lsu;
    assign bus.lsu_rvalid = finish & owner_lsu;
    // Aborted transactions and stores return zero data.
    assign bus.ifu_rdata  = (bus.ifu_rvalid & complete) ? bus.mem_rdata : '0;
    assign bus.lsu_rdata  = (bus.lsu_rvalid & complete & ~bus.mem_we) ? bus.mem_rdata : '0;

`ifdef NPC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;
    logic             err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == IDLE) cnt <= '0;
            else               cnt <= cnt + CNT_W'(1);
            if (abort) err_q <= 1'b1;
        end
    end

    assign abort       = (state != IDLE) & (cnt == CNT_W'(TIMEOUT)) & ~complete;
    assign bus.arb_err = err_q;
`else
    assign abort       = 1'b0;
    assign bus.arb_err = 1'b0;
`endif
endmodule
